// File: rtl/adder_arb_pkg.sv
// Shared types and sizing helpers for the shared-adder arbiter.
// Imported by the round-robin arbiter and the top level.
package adder_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Sum of two unsigned DATA_W operands needs one carry bit.
  function automatic int sum_w(input int data_w);
    return data_w + 1;
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned; a missing default here would infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered DATA_W-bit adder shared round-robin among NUM_REQ requesters,
// with valid/ready handshakes on both the operand and the result side.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int SUM_W  = sum_w(DATA_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [SUM_W-1:0]          rsp_sum,
  output logic                      busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     id_q;
  logic [DATA_W-1:0]    in1_q;
  logic [DATA_W-1:0]    in2_q;
  logic [SUM_W-1:0]     sum_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 any;
  logic [IDX_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]   id_onehot;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign next_ptr  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign id_onehot = NUM_REQ'(1) << id_q;

  // Grant depends only on state, rr_ptr and req_valid, never on rsp_ready.
  // It is also masked while reset is held so nothing looks accepted in reset.
  assign req_ready = (reset && (state == IDLE)) ? gnt : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign busy      = busy_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, including the operand/sum datapath, is reset so
      // rsp_sum reads 0 after reset and an aborted operation leaves no trace.
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      sum_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            in1_q  <= req_in1[int'(gnt_idx)*DATA_W +: DATA_W];
            in2_q  <= req_in2[int'(gnt_idx)*DATA_W +: DATA_W];
            id_q   <= gnt_idx;
            rr_ptr <= next_ptr;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_q       <= SUM_W'(in1_q) + SUM_W'(in2_q);
          rsp_valid_q <= id_onehot;
          state       <= RESP;
        end
        RESP: begin
          // Only the owning requester can retire the result.
          if (rsp_ready[id_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus random
// traffic scored against a transaction-level model of the sharing rules.
module tb_adder_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int SW = W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_in1;
  logic [N*W-1:0]    req_in2;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [SW-1:0]     rsp_sum;
  logic              busy;

  adder_share_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the adder, how far along it is,
  // and what the result bus should show.
  int m_ptr;      // next requester to be searched first
  int m_phase;    // 0 free, 1 operands taken, 2 result offered
  int m_id;
  int m_sum;
  int m_last;     // value visible on the result bus

  function automatic bit has(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (has(v, (p + k) % N)) return (p + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v == (N'(1) << k)) return k;
    return -1;
  endfunction

  function automatic int opnd(input logic [N*W-1:0] bus, input int i);
    return int'(bus[i*W +: W]);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_phase = 0; m_id = 0; m_sum = 0; m_last = 0;
  endtask

  task automatic model_advance();
    int w;
    case (m_phase)
      0: begin
        w = winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_id    = w;
          m_sum   = opnd(req_in1, w) + opnd(req_in2, w);
          m_ptr   = (w + 1) % N;
          m_phase = 1;
        end
      end
      1: begin
        m_last  = m_sum;
        m_phase = 2;
      end
      default: if (has(rsp_ready, m_id)) m_phase = 0;
    endcase
  endtask

  logic [N-1:0]  obs_ready, obs_rsp_valid;
  logic [SW-1:0] obs_sum;
  logic          obs_busy;

  // Apply one cycle of inputs just after a falling edge, compare the outputs
  // against the model, then advance the model across the coming rising edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] a,
                      input logic [N*W-1:0] b, input logic [N-1:0] rr);
    int w;
    logic [N-1:0] exp_ready, exp_rsp;
    reset = r; req_valid = v; req_in1 = a; req_in2 = b; rsp_ready = rr;
    if (!r) model_reset();
    #1;
    obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_sum = rsp_sum; obs_busy = busy;
    w = (r && m_phase == 0) ? winner(v, m_ptr) : -1;
    exp_ready = (w < 0) ? '0 : (N'(1) << w);
    exp_rsp   = (m_phase == 2) ? (N'(1) << m_id) : '0;
    check("busy",      32'(obs_busy),      (m_phase != 0) ? 32'd1 : 32'd0);
    check("req_ready", 32'(obs_ready),     32'(exp_ready));
    check("rsp_valid", 32'(obs_rsp_valid), 32'(exp_rsp));
    check("rsp_sum",   32'(obs_sum),       32'(m_last));
    if (r) model_advance();
    @(negedge clk);
  endtask

  logic [N*W-1:0] a, b;
  int g_idx[$], g_cyc[$], sums[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int exp_sums[5]  = '{10, 11, 12, 13, 10};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0; rsp_ready = '0;
    model_reset();
    @(negedge clk);

    // Reset with random inputs: every output must stay 0.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, N'($urandom), (N*W)'($urandom), (N*W)'($urandom), N'($urandom));
      check("rst_ready", 32'(obs_ready), 32'd0);
      check("rst_sum",   32'(obs_sum),   32'd0);
    end
    step(1'b1, '0, '0, '0, '0);
    step(1'b1, '0, '0, '0, '0);
    check("idle_busy", 32'(obs_busy), 32'd0);

    // Single op on requester 2: 7 + 9.
    a = '0; b = '0; a[2*W +: W] = 5'd7; b[2*W +: W] = 5'd9;
    step(1'b1, 4'b0100, a, b, 4'b0100);
    check("t2_grant", 32'(obs_ready), 32'd4);
    step(1'b1, 4'b0000, a, b, 4'b0100);
    check("t2_add_ready", 32'(obs_ready), 32'd0);
    check("t2_add_rsp",   32'(obs_rsp_valid), 32'd0);
    step(1'b1, 4'b0000, a, b, 4'b0100);
    check("t2_rsp_valid", 32'(obs_rsp_valid), 32'd4);
    check("t2_rsp_sum",   32'(obs_sum), 32'd16);

    // Largest operands on requester 0: carry bit must survive.
    a = '0; b = '0; a[0 +: W] = 5'd31; b[0 +: W] = 5'd31;
    step(1'b1, 4'b0001, a, b, 4'b0001);
    check("t3_grant", 32'(obs_ready), 32'd1);
    step(1'b1, 4'b0000, a, b, 4'b0001);
    step(1'b1, 4'b0000, a, b, 4'b0001);
    check("t3_rsp_sum", 32'(obs_sum), 32'd62);
    step(1'b1, 4'b0000, a, b, 4'b0001);
    check("t3_sum_held", 32'(obs_sum), 32'd62);

    // Fairness from a fresh pointer: all requesters active, in1=i, in2=10.
    step(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = W'(i);
      b[i*W +: W] = 5'd10;
    end
    for (int c = 0; c < 15; c++) begin
      step(1'b1, '1, a, b, '1);
      if (obs_ready != '0) begin
        g_idx.push_back(idx_of(obs_ready));
        g_cyc.push_back(c);
      end
      if (obs_rsp_valid != '0) sums.push_back(int'(obs_sum));
    end
    check("t4_ngrant", 32'(g_idx.size()), 32'd5);
    check("t4_nsum",   32'(sums.size()),  32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < g_idx.size()) check("t4_order", 32'(g_idx[k]), 32'(exp_order[k]));
      if (k > 0 && k < g_cyc.size()) check("t4_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
      if (k < sums.size()) check("t4_sum", 32'(sums[k]), 32'(exp_sums[k]));
    end

    // Backpressure on requester 1 while requester 3 tries to retire it.
    a[1*W +: W] = 5'd20; b[1*W +: W] = 5'd5;
    step(1'b1, '1, a, b, 4'b1000);
    check("t5_grant", 32'(obs_ready), 32'd2);
    step(1'b1, '1, a, b, 4'b1000);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, '1, a, b, 4'b1000);
      check("t5_hold_valid", 32'(obs_rsp_valid), 32'd2);
      check("t5_hold_sum",   32'(obs_sum), 32'd25);
      check("t5_hold_busy",  32'(obs_busy), 32'd1);
      check("t5_no_grant",   32'(obs_ready), 32'd0);
    end
    step(1'b1, '1, a, b, 4'b0010);
    step(1'b1, '1, a, b, 4'b0000);
    check("t5_next_grant", 32'(obs_ready), 32'd4);

    // Reset while the adder is working: no response, pointer back to 0.
    step(1'b0, '1, a, b, '1);
    check("t6_abort_rsp", 32'(obs_rsp_valid), 32'd0);
    step(1'b0, '1, a, b, '1);
    check("t6_abort_rsp2", 32'(obs_rsp_valid), 32'd0);
    step(1'b1, '1, a, b, '1);
    check("t6_first_grant", 32'(obs_ready), 32'd1);
    step(1'b1, '1, a, b, '1);
    step(1'b1, '1, a, b, '1);
    check("t6_sum", 32'(obs_sum), 32'd10);

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
           N'($urandom) & N'($urandom | $urandom),
           (N*W)'($urandom), (N*W)'($urandom),
           ($urandom_range(0, 2) != 0) ? N'($urandom) : '1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
